// File: rtl/miriscv_pipe_ctrl_pkg.sv
// miriscv_pipe_ctrl_pkg
//   Shared types and helpers for the parametrised pipeline control unit.
//   - pipe_ctrl_state_e : BOOT / RUN / DRAIN / HALTED control states
//   - BYP_NONE          : bypass-select value meaning "read the register file"
//   - calc_sel_w()      : bypass-select width for a given pipeline depth
//   - XLEN_DEF / GPR_ADDR_W_DEF : default datapath widths (mirror the core packages)
package miriscv_pipe_ctrl_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int GPR_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } pipe_ctrl_state_e;

    localparam int BYP_NONE = 0;

    // Select must encode 0 (no bypass) plus one code per producer stage.
    function automatic int calc_sel_w(input int pipe_stages);
        int nprod;
        nprod = pipe_stages - 2;
        return (nprod < 1) ? 1 : $clog2(nprod + 1);
    endfunction

endpackage

// File: rtl/miriscv_pipe_ctrl_fwd.sv
// miriscv_pipe_ctrl_fwd
//   Per-operand RAW hazard detection and bypass selection.
//   Ports:
//     rs_addr_i, rs_req_i   : consumer source register and its use flag
//     cons_valid_i          : stage-0 valid
//     prod_rd_addr_i        : rd per producer, index k-1 is stage k
//     prod_we_i/valid_i/late_i : producer write-enable, valid, not-yet-forwardable
//     sel_o                 : 0 = no bypass, k = forward from producer stage k
//     late_o                : selected producer cannot forward yet (load-use)
module miriscv_pipe_ctrl_fwd
    import miriscv_pipe_ctrl_pkg::*;
#(
    parameter int NPROD      = 3,
    parameter int GPR_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic [GPR_ADDR_W-1:0]            rs_addr_i,
    input  logic                             rs_req_i,
    input  logic                             cons_valid_i,
    input  logic [NPROD-1:0][GPR_ADDR_W-1:0] prod_rd_addr_i,
    input  logic [NPROD-1:0]                 prod_we_i,
    input  logic [NPROD-1:0]                 prod_valid_i,
    input  logic [NPROD-1:0]                 prod_late_i,
    output logic [SEL_W-1:0]                 sel_o,
    output logic                             late_o
);

    logic [NPROD-1:0] hit;

    always_comb begin
        hit = '0;
        for (int k = 0; k < NPROD; k++) begin
            hit[k] = rs_req_i & cons_valid_i & prod_we_i[k] & prod_valid_i[k]
                   & (prod_rd_addr_i[k] == rs_addr_i)
                   & (prod_rd_addr_i[k] != '0);
        end
    end

    // Walk from the farthest producer down so the nearest hit is written last.
    // The late flag follows the selected producer only, so a stale far load
    // never stalls an operand that a nearer producer already supplies.
    always_comb begin
        sel_o  = SEL_W'(BYP_NONE);
        late_o = 1'b0;
        for (int k = NPROD - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel_o  = SEL_W'(k + 1);
                late_o = prod_late_i[k];
            end
        end
    end

endmodule

// File: rtl/miriscv_pipe_ctrl.sv
// miriscv_pipe_ctrl
//   Pipeline control: RAW bypass select, load-use stall, stall cascade,
//   mispredict flush, boot-address forcing and a halt/drain/resume FSM.
//   Ports:
//     clk_i, arstn_i             : clock, asynchronous active-low reset
//     boot_addr_i                : PC forced while booting
//     stall_req_i, valid_i       : per-stage stall request / valid
//     rs*_addr_i, rs*_req_i      : stage-0 sources
//     prod_rd_addr_i/we_i/late_i : producer stages 1..PIPE_STAGES-2
//     res_*                      : resolve-stage branch outcome and PCs
//     halt_req_i, resume_req_i   : debug / power halt control
//     byp_sel1_o, byp_sel2_o     : bypass selects (0 = none)
//     stall_o, kill_o            : per-stage stall / kill
//     force_pc_o, force_f_o      : fetch redirect
//     halted_o                   : registered, pipeline drained and halted
//     perf_stall_cnt_o, perf_flush_cnt_o : performance counters
//   Build option: MIRISCV_PIPE_CTRL_PERF_EN enables the counters; otherwise
//   both outputs are tied to zero.
module miriscv_pipe_ctrl
    import miriscv_pipe_ctrl_pkg::*;
#(
    parameter int    PIPE_STAGES = 5,
    parameter int    BOOT_CYCLES = 2,
    parameter int    XLEN        = XLEN_DEF,
    parameter int    GPR_ADDR_W  = GPR_ADDR_W_DEF,
    localparam int   NPROD       = PIPE_STAGES - 2,
    localparam int   SEL_W       = calc_sel_w(PIPE_STAGES)
) (
    input  logic                             clk_i,
    input  logic                             arstn_i,
    input  logic [XLEN-1:0]                  boot_addr_i,
    input  logic [PIPE_STAGES-1:0]           stall_req_i,
    input  logic [PIPE_STAGES-1:0]           valid_i,
    input  logic [GPR_ADDR_W-1:0]            rs1_addr_i,
    input  logic [GPR_ADDR_W-1:0]            rs2_addr_i,
    input  logic                             rs1_req_i,
    input  logic                             rs2_req_i,
    input  logic [NPROD-1:0][GPR_ADDR_W-1:0] prod_rd_addr_i,
    input  logic [NPROD-1:0]                 prod_rd_we_i,
    input  logic [NPROD-1:0]                 prod_late_i,
    input  logic                             res_prediction_i,
    input  logic                             res_taken_i,
    input  logic [XLEN-1:0]                  res_target_pc_i,
    input  logic [XLEN-1:0]                  res_next_pc_i,
    input  logic                             halt_req_i,
    input  logic                             resume_req_i,
    output logic [SEL_W-1:0]                 byp_sel1_o,
    output logic [SEL_W-1:0]                 byp_sel2_o,
    output logic [PIPE_STAGES-1:0]           stall_o,
    output logic [PIPE_STAGES-1:0]           kill_o,
    output logic [XLEN-1:0]                  force_pc_o,
    output logic                             force_f_o,
    output logic                             halted_o,
    output logic [31:0]                      perf_stall_cnt_o,
    output logic [31:0]                      perf_flush_cnt_o
);

    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    pipe_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic             halted_q;

    logic late1, late2, hz_stall, mispred, drained;

    miriscv_pipe_ctrl_fwd #(.NPROD(NPROD), .GPR_ADDR_W(GPR_ADDR_W), .SEL_W(SEL_W)) u_fwd1 (
        .rs_addr_i      (rs1_addr_i),
        .rs_req_i       (rs1_req_i),
        .cons_valid_i   (valid_i[0]),
        .prod_rd_addr_i (prod_rd_addr_i),
        .prod_we_i      (prod_rd_we_i),
        .prod_valid_i   (valid_i[NPROD:1]),
        .prod_late_i    (prod_late_i),
        .sel_o          (byp_sel1_o),
        .late_o         (late1)
    );

    miriscv_pipe_ctrl_fwd #(.NPROD(NPROD), .GPR_ADDR_W(GPR_ADDR_W), .SEL_W(SEL_W)) u_fwd2 (
        .rs_addr_i      (rs2_addr_i),
        .rs_req_i       (rs2_req_i),
        .cons_valid_i   (valid_i[0]),
        .prod_rd_addr_i (prod_rd_addr_i),
        .prod_we_i      (prod_rd_we_i),
        .prod_valid_i   (valid_i[NPROD:1]),
        .prod_late_i    (prod_late_i),
        .sel_o          (byp_sel2_o),
        .late_o         (late2)
    );

    assign hz_stall = late1 | late2;
    assign drained  = (valid_i[PIPE_STAGES-1:1] == '0);
    assign mispred  = valid_i[PIPE_STAGES-1] & (res_prediction_i ^ res_taken_i)
                    & ((state_q == ST_RUN) | (state_q == ST_DRAIN));

    // A stage stalls when it or any later stage asks to.
    always_comb begin
        stall_o = '0;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            stall_o[s] = |(stall_req_i >> s);
        end
        stall_o[0] = stall_o[0] | hz_stall
                   | (state_q == ST_DRAIN) | (state_q == ST_HALTED);
    end

    always_comb begin
        kill_o     = mispred ? '1 : '0;
        force_pc_o = res_taken_i ? res_target_pc_i : res_next_pc_i;
        force_f_o  = mispred;
        if (state_q == ST_BOOT) begin
            force_pc_o = boot_addr_i;
            force_f_o  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
                else                         boot_cnt_d = boot_cnt_q + 1'b1;
            end
            ST_RUN:    if (halt_req_i)   state_d = ST_DRAIN;
            ST_DRAIN:  if (drained)      state_d = ST_HALTED;
            ST_HALTED: if (resume_req_i) state_d = ST_RUN;
            default:                     state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            halted_q   <= (state_d == ST_HALTED);
        end
    end

    assign halted_o = halted_q;

`ifdef MIRISCV_PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_o[0] && (state_q == ST_RUN)) perf_stall_q <= perf_stall_q + 32'd1;
            if (mispred)                           perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_miriscv_pipe_ctrl.sv
// Directed bench for miriscv_pipe_ctrl (PIPE_STAGES=5, BOOT_CYCLES=2).
module tb_miriscv_pipe_ctrl;

    logic              clk = 1'b0;
    logic              arstn = 1'b0;
    logic [31:0]       boot_addr;
    logic [4:0]        stall_req, valid;
    logic [4:0]        rs1, rs2;
    logic              rs1_req, rs2_req;
    logic [2:0][4:0]   prod_rd;
    logic [2:0]        prod_we, prod_late;
    logic              pred, taken;
    logic [31:0]       target, next_pc;
    logic              halt_req, resume_req;
    logic [1:0]        sel1, sel2;
    logic [4:0]        stall, kill;
    logic [31:0]       force_pc;
    logic              force_f, halted;
    logic [31:0]       perf_stall, perf_flush;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    miriscv_pipe_ctrl #(.PIPE_STAGES(5), .BOOT_CYCLES(2)) dut (
        .clk_i            (clk),
        .arstn_i          (arstn),
        .boot_addr_i      (boot_addr),
        .stall_req_i      (stall_req),
        .valid_i          (valid),
        .rs1_addr_i       (rs1),
        .rs2_addr_i       (rs2),
        .rs1_req_i        (rs1_req),
        .rs2_req_i        (rs2_req),
        .prod_rd_addr_i   (prod_rd),
        .prod_rd_we_i     (prod_we),
        .prod_late_i      (prod_late),
        .res_prediction_i (pred),
        .res_taken_i      (taken),
        .res_target_pc_i  (target),
        .res_next_pc_i    (next_pc),
        .halt_req_i       (halt_req),
        .resume_req_i     (resume_req),
        .byp_sel1_o       (sel1),
        .byp_sel2_o       (sel2),
        .stall_o          (stall),
        .kill_o           (kill),
        .force_pc_o       (force_pc),
        .force_f_o        (force_f),
        .halted_o         (halted),
        .perf_stall_cnt_o (perf_stall),
        .perf_flush_cnt_o (perf_flush)
    );

    typedef struct {
        logic [4:0]      sreq, vld, rs1, rs2;
        logic            r1, r2;
        logic [2:0][4:0] rd;
        logic [2:0]      we, late;
        logic            pred, tkn;
        logic [1:0]      e_s1, e_s2;
        logic [4:0]      e_stall, e_kill;
        logic            e_ff;
        logic [31:0]     e_pc;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mkv(input logic [4:0] sreq, vld, rs1_a, rs2_a,
                                 input logic r1, r2, input logic [14:0] rd,
                                 input logic [2:0] we, late, input logic p, t,
                                 input logic [1:0] s1, s2, input logic [4:0] st, kl,
                                 input logic ff, input logic [31:0] pc);
        vec_t v;
        v.sreq = sreq; v.vld = vld; v.rs1 = rs1_a; v.rs2 = rs2_a;
        v.r1 = r1; v.r2 = r2; v.rd = rd; v.we = we; v.late = late;
        v.pred = p; v.tkn = t; v.e_s1 = s1; v.e_s2 = s2;
        v.e_stall = st; v.e_kill = kl; v.e_ff = ff; v.e_pc = pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic quiet();
        stall_req = '0; valid = '0; rs1 = '0; rs2 = '0; rs1_req = 0; rs2_req = 0;
        prod_rd = '0; prod_we = '0; prod_late = '0; pred = 0; taken = 0;
        target = 32'h100; next_pc = 32'h200; halt_req = 0; resume_req = 0;
    endtask

    // Reset, then walk the two boot cycles checking the forced PC.
    task automatic reset_seq();
        @(negedge clk);
        quiet();
        boot_addr = 32'h8000_0000;
        arstn = 1'b0;
        #1;
        chk("rst_force_f", 32'(force_f), 32'd1);
        chk("rst_force_pc", force_pc, 32'h8000_0000);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
        chk("rst_perf_flush", perf_flush, 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        #2;
        chk("boot0_force_f", 32'(force_f), 32'd1);
        @(negedge clk);
        // Mispredict during boot: boot forcing wins and nothing is killed.
        valid = 5'b10000; taken = 1'b1;
        #2;
        chk("boot1_force_f", 32'(force_f), 32'd1);
        chk("boot1_force_pc", force_pc, 32'h8000_0000);
        chk("boot1_kill", 32'(kill), 32'd0);
        @(negedge clk);
        quiet();
        #2;
        chk("run_force_f", 32'(force_f), 32'd0);
        chk("run_stall0", 32'(stall), 32'd0);
    endtask

    initial begin
        quiet();
        boot_addr = 32'h8000_0000;

        //            sreq     vld      rs1 rs2 r1 r2 rd{p3,p2,p1}         we      late    p t  s1 s2 stall    kill     ff pc
        vecs[0]  = mkv(5'b00000,5'b11111,0, 0, 0, 0, {5'd0,5'd0,5'd0},   3'b000, 3'b000, 0,0, 0, 0, 5'b00000,5'b00000,0, 32'h200);
        vecs[1]  = mkv(5'b00000,5'b11111,5, 0, 1, 0, {5'd0,5'd5,5'd5},   3'b111, 3'b000, 0,0, 1, 0, 5'b00000,5'b00000,0, 32'h200);
        vecs[2]  = mkv(5'b00000,5'b11111,5, 0, 1, 0, {5'd0,5'd5,5'd0},   3'b111, 3'b000, 0,0, 2, 0, 5'b00000,5'b00000,0, 32'h200);
        vecs[3]  = mkv(5'b00000,5'b11111,0, 7, 0, 1, {5'd0,5'd0,5'd7},   3'b111, 3'b001, 0,0, 0, 1, 5'b00001,5'b00000,0, 32'h200);
        vecs[4]  = mkv(5'b00000,5'b11111,0, 7, 0, 1, {5'd0,5'd0,5'd7},   3'b111, 3'b000, 0,0, 0, 1, 5'b00000,5'b00000,0, 32'h200);
        vecs[5]  = mkv(5'b00000,5'b11111,0, 7, 0, 1, {5'd0,5'd7,5'd7},   3'b111, 3'b010, 0,0, 0, 1, 5'b00000,5'b00000,0, 32'h200);
        vecs[6]  = mkv(5'b00000,5'b11101,0, 7, 0, 1, {5'd0,5'd7,5'd7},   3'b111, 3'b000, 0,0, 0, 2, 5'b00000,5'b00000,0, 32'h200);
        vecs[7]  = mkv(5'b00000,5'b11110,5, 0, 1, 0, {5'd5,5'd5,5'd5},   3'b111, 3'b000, 0,0, 0, 0, 5'b00000,5'b00000,0, 32'h200);
        vecs[8]  = mkv(5'b00000,5'b11111,0, 0, 0, 0, {5'd0,5'd0,5'd0},   3'b000, 3'b000, 0,1, 0, 0, 5'b00000,5'b11111,1, 32'h100);
        vecs[9]  = mkv(5'b00000,5'b01111,0, 0, 0, 0, {5'd0,5'd0,5'd0},   3'b000, 3'b000, 0,1, 0, 0, 5'b00000,5'b00000,0, 32'h100);
        vecs[10] = mkv(5'b00000,5'b11111,0, 0, 0, 0, {5'd0,5'd0,5'd0},   3'b000, 3'b000, 1,0, 0, 0, 5'b00000,5'b11111,1, 32'h200);
        vecs[11] = mkv(5'b00100,5'b11111,0, 0, 0, 0, {5'd0,5'd0,5'd0},   3'b000, 3'b000, 0,0, 0, 0, 5'b00111,5'b00000,0, 32'h200);
        vecs[12] = mkv(5'b10000,5'b11111,9, 0, 1, 0, {5'd0,5'd0,5'd9},   3'b111, 3'b001, 0,0, 1, 0, 5'b11111,5'b00000,0, 32'h200);
        vecs[13] = mkv(5'b00000,5'b11111,3, 4, 1, 1, {5'd3,5'd4,5'd0},   3'b111, 3'b000, 0,0, 3, 2, 5'b00000,5'b00000,0, 32'h200);
        vecs[14] = mkv(5'b00000,5'b11111,3, 4, 1, 1, {5'd3,5'd4,5'd0},   3'b011, 3'b000, 0,0, 0, 2, 5'b00000,5'b00000,0, 32'h200);

        reset_seq();

        foreach (vecs[i]) begin
            @(negedge clk);
            stall_req = vecs[i].sreq; valid = vecs[i].vld;
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; rs1_req = vecs[i].r1; rs2_req = vecs[i].r2;
            prod_rd = vecs[i].rd; prod_we = vecs[i].we; prod_late = vecs[i].late;
            pred = vecs[i].pred; taken = vecs[i].tkn;
            #2;
            chk($sformatf("v%0d_sel1", i), 32'(sel1), 32'(vecs[i].e_s1));
            chk($sformatf("v%0d_sel2", i), 32'(sel2), 32'(vecs[i].e_s2));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_kill", i), 32'(kill), 32'(vecs[i].e_kill));
            chk($sformatf("v%0d_force_f", i), 32'(force_f), 32'(vecs[i].e_ff));
            chk($sformatf("v%0d_force_pc", i), force_pc, vecs[i].e_pc);
        end

        // Halt with stages 1..3 valid, draining one stage per cycle.
        @(negedge clk);
        quiet(); valid = 5'b01110; halt_req = 1'b1;
        #2;
        chk("halt_req_stall0", 32'(stall[0]), 32'd0);
        @(negedge clk);
        halt_req = 1'b0; valid = 5'b01100;
        #2;
        chk("drain1_stall0", 32'(stall[0]), 32'd1);
        chk("drain1_halted", 32'(halted), 32'd0);
        @(negedge clk);
        valid = 5'b01000;
        #2;
        chk("drain2_stall0", 32'(stall[0]), 32'd1);
        chk("drain2_halted", 32'(halted), 32'd0);
        @(negedge clk);
        valid = 5'b00000;
        #2;
        chk("drain3_stall0", 32'(stall[0]), 32'd1);
        chk("drain3_halted", 32'(halted), 32'd0);
        @(negedge clk);
        #2;
        chk("halted_rise", 32'(halted), 32'd1);
        chk("halted_stall0", 32'(stall[0]), 32'd1);
        resume_req = 1'b1;
        @(negedge clk);
        resume_req = 1'b0;
        #2;
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_stall0", 32'(stall[0]), 32'd0);

        // Halt again with an empty pipe, then reset out of HALTED.
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rehalt_halted", 32'(halted), 32'd1);

        // Counter sequence: 4 load-use stall cycles then one mispredict.
        reset_seq();
        valid = 5'b11111; rs1 = 5'd9; rs1_req = 1'b1;
        prod_rd = {5'd0, 5'd0, 5'd9}; prod_we = 3'b001; prod_late = 3'b001;
        repeat (4) @(negedge clk);
        quiet(); valid = 5'b10000; taken = 1'b1;
        @(negedge clk);
        quiet();
        #2;
`ifdef MIRISCV_PIPE_CTRL_PERF_EN
        chk("perf_stall_cnt", perf_stall, 32'd4);
        chk("perf_flush_cnt", perf_flush, 32'd1);
`else
        chk("perf_stall_cnt", perf_stall, 32'd0);
        chk("perf_flush_cnt", perf_flush, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
